seq_reader_11b: RTL and testbench



---
 rtl/seq_reader_11b.sv | 114 +++++++++++
 tb/tb_seq_reader_11b.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_reader_11b.sv
// Read-back engine for the 11-bit string buffer: one RD/CAP/OUT trip per word.
// Define SEQ_READER_REVERSE_EN to emit words last-written first.
module seq_reader_11b #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_OUT,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              last_word;

`ifdef SEQ_READER_REVERSE_EN
    assign last_word = (idx_q == '0);
`else
    assign last_word = (idx_q == len_q - ADDR_W'(1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = S_FIN;
                    end else begin
                        len_d   = len;
`ifdef SEQ_READER_REVERSE_EN
                        idx_d   = len - ADDR_W'(1);
`else
                        idx_d   = '0;
`endif
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                // RAM data for the RD address is valid during this cycle
                out_data_d = mem_rdata;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (last_word) begin
                        state_d = S_FIN;
                    end else begin
`ifdef SEQ_READER_REVERSE_EN
                        idx_d   = idx_q - ADDR_W'(1);
`else
                        idx_d   = idx_q + ADDR_W'(1);
`endif
                        state_d = S_RD;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_en    = (state_q == S_RD);
    assign mem_addr  = idx_q;
    assign out_data  = out_data_q;
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_seq_reader_11b.sv
// Bench for seq_reader_11b: timing-rule scoreboard checked every cycle,
// plus directed passes with literal expectations.
module tb_seq_reader_11b;

    localparam int DW = 8;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] len = '0;
    logic          out_ready = 1'b1;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [2048];

    int n_chk = 0;
    int n_pass = 0;

    seq_reader_11b #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Scoreboard: each word is read 1 cycle and offered 3 cycles after
    // the accept/handshake that precedes it; done follows the last handshake.
    int            cyc = 0;
    bit            act = 0;
    int            t_evt = 0;
    int            done_at = -1;
    logic [DW-1:0] wq [$];
    int            aq [$];
    int            hs_cnt = 0;
    int            max_addr = -1;

    always @(negedge clk) begin
        bit idle, ev, em;
        int a;
        cyc++;
        if (reset) begin
            chk("reset_outs",
                {mem_en, out_valid, busy, done, mem_addr, out_data}, 0);
            act = 0;
            done_at = -1;
            wq.delete();
            aq.delete();
        end else begin
            idle = !act && done_at != cyc;
            em = act && wq.size() > 0 && cyc == t_evt + 1;
            ev = act && wq.size() > 0 && cyc >= t_evt + 3;
            chk("busy", busy, !idle);
            chk("mem_en", mem_en, em);
            chk("out_valid", out_valid, ev);
            chk("done", done, done_at == cyc);
            if (mem_en && int'(mem_addr) > max_addr) max_addr = mem_addr;
            if (em) chk("mem_addr", mem_addr, aq[0]);
            if (ev) chk("out_data", out_data, wq[0]);
            if (ev && out_ready) begin
                hs_cnt++;
                void'(wq.pop_front());
                void'(aq.pop_front());
                t_evt = cyc;
                if (wq.size() == 0) begin
                    act = 0;
                    done_at = cyc + 1;
                end
            end
            if (idle && start) begin
                if (len == 0) begin
                    done_at = cyc + 1;
                end else begin
                    for (int i = 0; i < int'(len); i++) begin
`ifdef SEQ_READER_REVERSE_EN
                        a = int'(len) - 1 - i;
`else
                        a = i;
`endif
                        aq.push_back(a);
                        wq.push_back(mem[a]);
                    end
                    act = 1;
                    t_evt = cyc;
                end
            end
        end
    end

    task automatic do_start(input int l);
        @(posedge clk);
        #1 start = 1'b1;
        len = AW'(l);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy && !done) return;
        end
        chk("wait_idle_timeout", 0, 1);
    endtask

    logic [DW-1:0] w0, w2;
    int h0;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = DW'(i * 7 + 3);
        mem[0] = 8'h41;
        mem[1] = 8'h42;
        mem[2] = 8'h43;
`ifdef SEQ_READER_REVERSE_EN
        w0 = 8'h43;
        w2 = 8'h41;
`else
        w0 = 8'h41;
        w2 = 8'h43;
`endif
        repeat (3) @(posedge clk);
        #1 chk("reset_state",
               {mem_en, out_valid, busy, done, mem_addr, out_data}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // basic pass
        do_start(3);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 3) chk("basic_w0", {out_valid, out_data}, {1'b1, w0});
            if (k == 6) chk("basic_w1", {out_valid, out_data}, {1'b1, 8'h42});
            if (k == 9) chk("basic_w2", {out_valid, out_data}, {1'b1, w2});
            if (k == 10) chk("basic_done", done, 1);
            if (k == 11) chk("basic_busy_low", busy, 0);
        end

        // backpressure on the middle word: cycles 6..10
        do_start(3);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 8) chk("bp_hold", {out_valid, mem_en, out_data},
                            {1'b1, 1'b0, 8'h42});
            if (k == 12) chk("bp_rd_after_hs", mem_en, 1);
            if (k == 15) chk("bp_done", done, 1);
            @(posedge clk);
            #1 out_ready = !((k + 1) >= 6 && (k + 1) <= 10);
        end
        out_ready = 1'b1;
        wait_idle(20);

        // empty pass
        do_start(0);
        @(negedge clk);
        chk("empty_c1", {done, busy, mem_en, out_valid}, 4'b1100);
        @(negedge clk);
        chk("empty_c2", {done, busy}, 2'b00);

        // start during a pass is ignored
        h0 = hs_cnt;
        do_start(5);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        len = AW'(2);
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(100);
        chk("ignored_start_hs", hs_cnt - h0, 5);

        // reset while in OUT
        out_ready = 1'b0;
        do_start(4);
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        chk("reached_out", out_valid, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("mid_reset_outs",
               {mem_en, out_valid, busy, done, mem_addr, out_data}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_done_after_reset", {done, busy}, 0);
        end
        h0 = hs_cnt;
        do_start(2);
        wait_idle(50);
        chk("post_reset_hs", hs_cnt - h0, 2);

        // maximum length
        max_addr = -1;
        h0 = hs_cnt;
        do_start(2047);
        wait_idle(7000);
        chk("max_hs", hs_cnt - h0, 2047);
        chk("max_addr", max_addr, 2046);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
